vc_trace_capture: RTL
=====================

VC_TRACE_CAPTURE -- requirements
Module: vc_trace_capture

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-low.
REQ-002 Parameter p_nchan, default 4: number of traced val/rdy channels, 1..16.
REQ-003 Parameter p_nbits, default 8: message bits per channel.
REQ-004 Parameter p_depth, default 16: entries in the capture buffer; power of two, 2..1024.
REQ-005 Parameter p_cbits, default 16: cycle-stamp width.
REQ-006 Local width W = p_cbits + 2*p_nchan + p_nchan*p_nbits; local width A = clog2(p_depth)+1.
REQ-007 Port clk, input, 1: clock; all state updates on posedge.
REQ-008 Port reset, input, 1: synchronous active-low reset (0 = reset).
REQ-009 Port mode, input, 1: 0 = wrap (flight recorder); 1 = fill-and-stop.
REQ-010 Port arm, input, 1: start a new capture.
REQ-011 Port trig, input, 1: trigger event.
REQ-012 Port post_count, input, A: number of events to record after the trigger.
REQ-013 Port chan_val, input, p_nchan: per-channel valid.
REQ-014 Port chan_rdy, input, p_nchan: per-channel ready.
REQ-015 Port chan_msg, input, p_nchan*p_nbits: channel i message in bits [i*p_nbits +: p_nbits].
REQ-016 Port out_val, output, 1: drain entry valid.
REQ-017 Port out_rdy, input, 1: drain consumer ready.
REQ-018 Port out_msg, output, W: {stamp, chan_val, chan_rdy, chan_msg}, with stamp in the MSBs.
REQ-019 Port state, output, 2: IDLE=0, CAPTURE=1, POST=2, DRAIN=3.
REQ-020 Port count, output, A: number of occupied entries.

Function
REQ-021 Free-running stamp counter (p_cbits) SHALL increment every non-reset cycle, wrap modulo 2^p_cbits, and be sampled as the entry stamp.
REQ-022 An event SHALL be any cycle with |chan_val == 1 while state is CAPTURE or POST; exactly one entry is written per event, in that same cycle.
REQ-023 IDLE: arm=1 -> CAPTURE next cycle with count, write and read pointers cleared; trig SHALL be ignored in IDLE, including when asserted with arm.
REQ-024 CAPTURE: trig=1 -> POST with the post counter loaded from post_count; if post_count==0, -> DRAIN instead.
REQ-025 The event in the trigger cycle SHALL be recorded and SHALL NOT decrement the post counter.
REQ-026 POST: each recorded event decrements the post counter; the event that brings it to 0 is recorded, and the state becomes DRAIN next cycle.
REQ-027 Wrap mode, buffer full (count==p_depth) at an event: overwrite the oldest entry, advance the read pointer, and hold count at p_depth.
REQ-028 Stop mode, buffer full: the event SHALL NOT be written, and the state SHALL go to DRAIN next cycle, overriding trig and the post counter.
REQ-029 Stop mode, event that makes count==p_depth: that event is written, then -> DRAIN.
REQ-030 DRAIN: out_val = (count!=0) and out_msg = the entry at the read pointer (oldest first); both outputs SHALL be combinational from registered state.
REQ-031 DRAIN: on out_val&&out_rdy, pop one entry (read pointer+1, count-1); pop of the last entry -> IDLE next cycle; DRAIN entered with count==0 -> IDLE next cycle.
REQ-032 arm SHALL be ignored in CAPTURE, POST and DRAIN; no entries are written in DRAIN or IDLE.
REQ-033 out_val SHALL be 0 in every state except DRAIN, and out_msg is don't-care when out_val=0.
REQ-034 Pointers SHALL wrap modulo p_depth, and count SHALL never exceed p_depth nor underflow.
REQ-035 mode SHALL be sampled every cycle; the engineer integrating the block holds it stable from arm to the return to IDLE, and behaviour under a mid-capture mode change is unspecified.

Reset
REQ-036 reset==0 at posedge: state=IDLE, count=0, pointers=0, post counter=0, stamp=0, out_val=0; buffer contents unchanged and unreadable.
REQ-037 Reset asserted in any state, including mid-drain, SHALL abort that activity with no further pops or writes.

Verification
REQ-038 Reset release; arm at stamp 2; chan_val=0001 on cycles 5,6; trig at cycle 7 with chan_val=0; post_count=2; events on cycles 9,10 -> DRAIN at cycle 11; 4 entries popped in order with stamps 5,6,9,10; then IDLE.
REQ-039 p_depth=4, wrap mode; 6 events with stamps 10..15, then trig with post_count=0 -> count=4; drain yields stamps 12,13,14,15.
REQ-040 p_depth=4, stop mode; 5 events -> 4 entries written, DRAIN on the cycle after the 4th event, 5th event absent from the drained output.
REQ-041 DRAIN with out_rdy toggling 1,0,1,0 -> one pop per out_rdy=1 cycle; out_msg stable while out_rdy=0.
REQ-042 arm and trig asserted together in IDLE -> CAPTURE (not POST); arm pulsed in POST -> no effect on the post counter or pointers.
REQ-043 Reset asserted mid-drain with count=3 -> next cycle state=IDLE, count=0, out_val=0.

Source files
------------

// File: rtl/vc_trace_capture.sv
// Trace capture buffer for val/rdy channels: records stamped channel snapshots
// around a trigger, in wrap (flight recorder) or fill-and-stop mode, then drains them oldest first.
module vc_trace_capture #(
   parameter int p_nchan = 4,
   parameter int p_nbits = 8,
   parameter int p_depth = 16,
   parameter int p_cbits = 16,
   localparam int W = p_cbits + 2*p_nchan + p_nchan*p_nbits,
   localparam int A = $clog2(p_depth) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mode,
   input  logic                       arm,
   input  logic                       trig,
   input  logic [A-1:0]               post_count,
   input  logic [p_nchan-1:0]         chan_val,
   input  logic [p_nchan-1:0]         chan_rdy,
   input  logic [p_nchan*p_nbits-1:0] chan_msg,
   output logic                       out_val,
   input  logic                       out_rdy,
   output logic [W-1:0]               out_msg,
   output logic [1:0]                 state,
   output logic [A-1:0]               count
);

   // state    | meaning
   // IDLE     | waiting for arm; buffer contents held
   // CAPTURE  | recording events, waiting for trig
   // POST     | recording events until the post counter expires
   // DRAIN    | presenting entries oldest first on out_val/out_rdy
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   localparam int PW = $clog2(p_depth);
   localparam logic [A-1:0] c_full    = A'(p_depth);
   localparam logic [A-1:0] c_full_m1 = A'(p_depth - 1);
   localparam logic [A-1:0] c_one     = A'(1);

   state_t               state_q, state_d;
   logic [A-1:0]         count_q, count_d;
   logic [A-1:0]         post_q, post_d;
   logic [PW-1:0]        wptr_q, wptr_d;
   logic [PW-1:0]        rptr_q, rptr_d;
   logic [p_cbits-1:0]   stamp_q, stamp_d;
   logic [W-1:0]         mem_q [p_depth];

   logic                 is_event;
   logic                 full;
   logic                 stop_full;
   logic                 to_drain;
   logic                 wr_en;
   logic [W-1:0]         wr_data;

   assign is_event = |chan_val;
   assign full     = (count_q == c_full);
   assign stop_full = full && mode;
   assign wr_data  = {stamp_q, chan_val, chan_rdy, chan_msg};

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      post_d   = post_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      stamp_d  = stamp_q + 1'b1;
      wr_en    = 1'b0;
      to_drain = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_CAPTURE;
               count_d = '0;
               post_d  = '0;
               wptr_d  = '0;
               rptr_d  = '0;
            end
         end
         ST_CAPTURE, ST_POST: begin
            if (is_event) begin
               if (stop_full) begin
                  to_drain = 1'b1;
               end else begin
                  wr_en  = 1'b1;
                  wptr_d = wptr_q + 1'b1;
                  // a full wrap-mode buffer drops its oldest entry
                  if (full) rptr_d = rptr_q + 1'b1;
                  else      count_d = count_q + 1'b1;
                  if (mode && (count_q == c_full_m1)) to_drain = 1'b1;
               end
            end
            if (state_q == ST_CAPTURE) begin
               if (trig) begin
                  post_d = post_count;
                  if (post_count == '0) to_drain = 1'b1;
                  else                  state_d  = ST_POST;
               end
            end else if (is_event && !stop_full) begin
               post_d = post_q - 1'b1;
               if (post_q == c_one) to_drain = 1'b1;
            end
            if (to_drain) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (count_q == '0) begin
               state_d = ST_IDLE;
            end else if (out_rdy) begin
               rptr_d  = rptr_q + 1'b1;
               count_d = count_q - 1'b1;
               if (count_q == c_one) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         post_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         stamp_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         post_q  <= post_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         stamp_q <= stamp_d;
      end
   end

   // buffer storage is deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (reset && wr_en) mem_q[wptr_q] <= wr_data;
   end

   assign out_val = (state_q == ST_DRAIN) && (count_q != '0);
   assign out_msg = mem_q[rptr_q];
   assign state   = state_q;
   assign count   = count_q;

endmodule
